cmos_cfg_seq: RTL and testbench
===============================

// Module: cmos_cfg_seq
// PURPOSE
//  Power-up register-configuration sequencer for the CMOS sensor; sits directly upstream of the
//  I2C master and drives its write/wr_address/wr_data/iic_slave_addr inputs. After a power-up
//  delay it walks an external register table (sync ROM, {addr16,data8} per entry), issues one
//  I2C write per entry, supports in-table delay markers, and flags completion or a timeout error.
// PARAMETERS
//  SLAVE_ADDR   7'h3C       7-bit sensor I2C address, driven constant on iic_slave_addr
//  REG_NUM      256         number of table entries, indices 0..REG_NUM-1
//  IDX_W        8           width of cfg_index, REG_NUM <= 2**IDX_W
//  PWRUP_CYC    1_000_000   clocks waited after reset or start before the first entry (20 ms at 50 MHz)
//  MS_CYC       50_000      clocks per delay-marker unit (1 ms)
//  GAP_CYC      100         idle clocks between consecutive I2C transactions
//  TIMEOUT_CYC  2_000_000   max clocks from asserting write to seeing wr_done
// PORTS
//  clk            in   1      system clock, 50 MHz
//  rst_n          in   1      asynchronous reset, active low
//  cfg_start      in   1      1-cycle pulse: restart the whole sequence, accepted in DONE/ERROR only
//  cfg_index      out  IDX_W  table read address
//  cfg_entry      in   24     table word {reg_addr[23:8], reg_data[7:0]}, valid 1 clk after cfg_index
//  iic_slave_addr out  7      = SLAVE_ADDR
//  wr_address     out  16     register address of the current write
//  wr_data        out  8      data byte of the current write
//  write          out  1      write request level to the I2C master
//  wr_done        in   1      1-cycle pulse from the I2C master at the end of STOP
//  read           out  1      tied 0
//  cfg_busy       out  1      1 in every state except DONE and ERROR
//  cfg_done       out  1      level, 1 in DONE
//  cfg_err        out  1      level, 1 in ERROR
// BEHAVIOUR
//  Reset: state=PWR_WAIT, cfg_index=0, write=0, wr_address=0, wr_data=0, cfg_done=0, cfg_err=0,
//   cfg_busy=1, all counters 0. A reset mid-transaction drops write at once and the sequence restarts.
//  FSM states: PWR_WAIT, FETCH, DECODE, ISSUE, GAP, DELAY, DONE, ERROR.
//  PWR_WAIT: count PWRUP_CYC clocks, then go to FETCH. cfg_index is 0 on entry.
//  FETCH: 1 clock of ROM latency, then DECODE.
//  DECODE: register cfg_entry into wr_address and wr_data.
//   - reg_addr == 16'hFFFF: delay marker; load reg_data*MS_CYC into the delay counter and go to DELAY.
//     reg_data == 0 gives zero delay and goes directly to advance.
//   - otherwise: go to ISSUE and set write=1 in the same edge.
//  ISSUE: hold write=1, wr_address and wr_data stable (the master samples them throughout).
//   - wr_done seen: write <= 0 on that edge, go to GAP. write is low by the master's next IDLE cycle,
//     so no repeat transaction can start.
//   - timeout counter reaches TIMEOUT_CYC-1 without wr_done: write <= 0, go to ERROR.
//  GAP: wait GAP_CYC clocks, then advance.
//  DELAY: count down the delay counter to 0, then advance.
//  Advance: if cfg_index == REG_NUM-1, go to DONE; otherwise cfg_index += 1 and go to FETCH.
//   cfg_index never wraps.
//  DONE and ERROR: write=0; hold until cfg_start. cfg_start resets cfg_index to 0, clears cfg_done and
//   cfg_err, and goes to PWR_WAIT. cfg_start in any other state is ignored.
//  wr_done outside ISSUE is ignored. wr_done and the timeout in the same cycle: wr_done wins.
//  Delay multiply: 8b x MS_CYC into a counter at least 8+clog2(MS_CYC) bits wide; no overflow.
// TESTING
//  1 Reset, REG_NUM=3, table {0x3008,0x82},{0x3103,0x03},{0x3017,0xFF}; model wr_done 40 clk after write
//    -> exactly 3 writes in table order, cfg_done=1 after the 3rd GAP, cfg_index stops at 2.
//  2 Entry 1 = {0xFFFF,0x05}, MS_CYC=10 -> no write for that entry; 50 (+-2) clk pause before entry 2.
//  3 wr_done never returned -> write drops after TIMEOUT_CYC clocks, cfg_err=1, cfg_busy=0, no further writes.
//  4 In ERROR pulse cfg_start -> cfg_err=0, PWRUP_CYC wait, sequence restarts from index 0.
//  5 rst_n asserted while write=1 -> write=0 immediately; after release, PWR_WAIT then index 0.
//  6 Spurious wr_done pulses in GAP/DELAY and cfg_start while busy -> no state or index change.

Source files
------------

// File: rtl/cmos_cfg_seq.sv
// cmos_cfg_seq - power-up register-configuration sequencer for the CMOS sensor.
//
// After a power-up wait it walks an external synchronous register table
// ({reg_addr[23:8], reg_data[7:0]} per entry, valid one clock after the index),
// issues one I2C write per entry to the downstream I2C master, honours delay
// markers (reg_addr == 16'hFFFF, reg_data = milliseconds) and reports either
// completion or a write timeout.
//
// Ports
//   i_clk            system clock
//   i_rst_n          asynchronous reset, active low
//   i_cfg_start      1-cycle restart pulse, honoured only in DONE / ERROR
//   o_cfg_index      table read address
//   i_cfg_entry      table word, valid one clock after o_cfg_index
//   o_iic_slave_addr constant 7-bit sensor address
//   o_wr_address     register address of the current write
//   o_wr_data        data byte of the current write
//   o_write          write request level to the I2C master
//   i_wr_done        1-cycle pulse from the I2C master at the end of STOP
//   o_read           tied low
//   o_cfg_busy       high in every state except DONE and ERROR
//   o_cfg_done       high in DONE
//   o_cfg_err        high in ERROR
module cmos_cfg_seq #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h3C,
  parameter int         REG_NUM     = 256,
  parameter int         IDX_W       = 8,
  parameter int         PWRUP_CYC   = 1_000_000,
  parameter int         MS_CYC      = 50_000,
  parameter int         GAP_CYC     = 100,
  parameter int         TIMEOUT_CYC = 2_000_000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_start,
  output logic [IDX_W-1:0] o_cfg_index,
  input  logic [23:0]      i_cfg_entry,
  output logic [6:0]       o_iic_slave_addr,
  output logic [15:0]      o_wr_address,
  output logic [7:0]       o_wr_data,
  output logic             o_write,
  input  logic             i_wr_done,
  output logic             o_read,
  output logic             o_cfg_busy,
  output logic             o_cfg_done,
  output logic             o_cfg_err
);

  // One shared counter serves the power-up wait, the write timeout, the
  // inter-transaction gap and the delay countdown; size it for the largest.
  localparam int DLY_W = 8 + $clog2(MS_CYC);
  localparam int PWR_W = $clog2(PWRUP_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int W_A   = (DLY_W > PWR_W) ? DLY_W : PWR_W;
  localparam int W_B   = (TO_W > GAP_W) ? TO_W : GAP_W;
  localparam int CNT_W = (W_A > W_B) ? W_A : W_B;

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REG_NUM - 1);

  typedef enum logic [2:0] {
    S_PWR_WAIT = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_ISSUE    = 3'd3,
    S_GAP      = 3'd4,
    S_DELAY    = 3'd5,
    S_DONE     = 3'd6,
    S_ERROR    = 3'd7
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_index;
  logic             r_write;
  logic [15:0]      r_addr;
  logic [7:0]       r_data;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0] w_index_nxt;
  logic             w_write_nxt;
  logic [15:0]      w_addr_nxt;
  logic [7:0]       w_data_nxt;
  logic             w_adv;
  logic             w_marker;
  logic [CNT_W-1:0] w_dly;

  assign w_marker = (i_cfg_entry[23:8] == 16'hFFFF);
  // 8-bit millisecond count times MS_CYC always fits in DLY_W <= CNT_W bits.
  assign w_dly    = CNT_W'(i_cfg_entry[7:0]) * CNT_W'(MS_CYC);

  // Next-state, counter, index and write-request decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_index_nxt = r_index;
    w_write_nxt = r_write;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_adv       = 1'b0;

    case (r_state)
      S_PWR_WAIT: begin
        if (r_cnt == PWR_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_FETCH;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_FETCH: begin
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        w_addr_nxt = i_cfg_entry[23:8];
        w_data_nxt = i_cfg_entry[7:0];
        if (w_marker) begin
          if (i_cfg_entry[7:0] == 8'd0) begin
            w_adv = 1'b1;
          end else begin
            w_cnt_nxt   = w_dly;
            w_state_nxt = S_DELAY;
          end
        end else begin
          w_cnt_nxt   = '0;
          w_write_nxt = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // wr_done takes priority over a timeout expiring in the same cycle.
        if (i_wr_done) begin
          w_write_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_GAP;
        end else if (r_cnt == TO_LAST) begin
          w_write_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_ERROR;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt = '0;
          w_adv     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DELAY: begin
        // Loaded with N, so the state lasts exactly N clocks.
        if (r_cnt <= CNT_W'(1)) begin
          w_cnt_nxt = '0;
          w_adv     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_DONE, S_ERROR: begin
        w_write_nxt = 1'b0;
        if (i_cfg_start) begin
          w_index_nxt = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_PWR_WAIT;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_write_nxt = 1'b0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_ERROR;
      end
    endcase

    // Step to the next table entry, stopping on the last one (no wrap).
    if (w_adv) begin
      if (r_index == IDX_LAST) begin
        w_state_nxt = S_DONE;
      end else begin
        w_index_nxt = r_index + IDX_W'(1);
        w_state_nxt = S_FETCH;
      end
    end else begin
      w_index_nxt = w_index_nxt;
    end
  end

  // State, datapath and status registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_PWR_WAIT;
      r_cnt   <= '0;
      r_index <= '0;
      r_write <= 1'b0;
      r_addr  <= 16'd0;
      r_data  <= 8'd0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_index <= w_index_nxt;
      r_write <= w_write_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_busy  <= (w_state_nxt != S_DONE) && (w_state_nxt != S_ERROR);
      r_done  <= (w_state_nxt == S_DONE);
      r_err   <= (w_state_nxt == S_ERROR);
    end
  end

  assign o_cfg_index      = r_index;
  assign o_iic_slave_addr = SLAVE_ADDR;
  assign o_wr_address     = r_addr;
  assign o_wr_data        = r_data;
  assign o_write          = r_write;
  assign o_read           = 1'b0;
  assign o_cfg_busy       = r_busy;
  assign o_cfg_done       = r_done;
  assign o_cfg_err        = r_err;

endmodule

// File: tb/tb_cmos_cfg_seq.sv
// Self-checking bench for cmos_cfg_seq with small timing parameters.
// A behavioural model predicts, from the table contents and the responder's
// latency rule, the interval of every write request, its address/data and the
// interval at which DONE or ERROR is reached.
module tb_cmos_cfg_seq;
  localparam int REG_NUM = 4;
  localparam int IDX_W   = 3;
  localparam int PWRUP   = 20;
  localparam int MS      = 10;
  localparam int GAP     = 5;
  localparam int TO      = 60;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_start = 1'b0;
  logic             wr_done = 1'b0;
  logic [23:0]      cfg_entry = 24'd0;
  logic [IDX_W-1:0] cfg_index;
  logic [6:0]       iic_slave_addr;
  logic [15:0]      wr_address;
  logic [7:0]       wr_data;
  logic             write, read, cfg_busy, cfg_done, cfg_err;

  cmos_cfg_seq #(
    .SLAVE_ADDR(7'h3C), .REG_NUM(REG_NUM), .IDX_W(IDX_W), .PWRUP_CYC(PWRUP),
    .MS_CYC(MS), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_start(cfg_start),
    .o_cfg_index(cfg_index), .i_cfg_entry(cfg_entry),
    .o_iic_slave_addr(iic_slave_addr), .o_wr_address(wr_address),
    .o_wr_data(wr_data), .o_write(write), .i_wr_done(wr_done), .o_read(read),
    .o_cfg_busy(cfg_busy), .o_cfg_done(cfg_done), .o_cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  logic [23:0] rom [8];
  int iv = 0;
  int base = 0;
  int checks = 0, passes = 0, fails = 0;
  bit master_en = 1'b1;
  int lat_base = 0;

  int          rise_q[$];
  logic [23:0] wv_q[$];
  int          fall_q[$];
  int          done_iv = -1, err_iv = -1;

  // Synchronous table ROM: word valid one clock after the index.
  always @(posedge clk) cfg_entry <= rom[cfg_index];

  // Interval counter.
  always @(posedge clk) iv <= iv + 1;

  function automatic int lat_of(input logic [7:0] d);
    return (lat_base + int'(d)) % 41;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Event monitor: write rises/falls, DONE and ERROR entry.
  initial begin : monitor
    logic pw, pd, pe;
    pw = 1'b0; pd = 1'b0; pe = 1'b0;
    forever begin
      @(negedge clk);
      if (write && !pw) begin
        rise_q.push_back(iv);
        wv_q.push_back({wr_address, wr_data});
      end
      if (!write && pw) fall_q.push_back(iv);
      if (cfg_done && !pd) done_iv = iv;
      if (cfg_err && !pe) err_iv = iv;
      pw = write; pd = cfg_done; pe = cfg_err;
    end
  end

  // I2C master model: wr_done after a data-dependent latency, plus random
  // spurious pulses whenever no write is requested.
  initial begin : master
    int lc;
    bit seen;
    lc = -1; seen = 1'b0;
    forever begin
      @(negedge clk);
      wr_done = 1'b0;
      if (!rst_n) begin
        lc = -1; seen = 1'b0;
      end else if (lc == 0) begin
        wr_done = 1'b1; lc = -1;
      end else if (lc > 0) begin
        lc--;
      end else if (write && !seen && master_en) begin
        lc = lat_of(wr_data); seen = 1'b1;
      end else if (!write && $urandom_range(0, 7) == 0) begin
        wr_done = 1'b1;
      end
      if (!write) seen = 1'b0;
    end
  end

  task automatic clear_log();
    rise_q.delete(); wv_q.delete(); fall_q.delete();
    done_iv = -1; err_iv = -1;
  endtask

  task automatic do_reset(input bit check_state);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    if (check_state) begin
      chk("rst_write", write, 0);
      chk("rst_index", cfg_index, 0);
      chk("rst_busy", cfg_busy, 1);
      chk("rst_done", cfg_done, 0);
      chk("rst_err", cfg_err, 0);
      chk("rst_wr_addr", wr_address, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("read_tied", read, 0);
      chk("slave_addr", iic_slave_addr, 7'h3C);
    end
    clear_log();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = iv;
  endtask

  // Predict the run from the table and compare against the logged events.
  task automatic run_check(input string nm, input bit expect_to);
    int f, exp_end, st_at;
    int exp_rise[$];
    logic [23:0] exp_wv[$];
    f = PWRUP; exp_end = 0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (rom[i][23:8] == 16'hFFFF) begin
        f = f + 2 + int'(rom[i][7:0]) * MS;
      end else begin
        exp_rise.push_back(f + 2);
        exp_wv.push_back(rom[i]);
        if (expect_to) begin
          exp_end = f + 2 + TO;
          break;
        end
        f = f + 2 + lat_of(rom[i][7:0]) + 1 + GAP + 1;
      end
    end
    if (!expect_to) exp_end = f;
    st_at = $urandom_range(1, exp_end - 4);
    for (int n = 0; n < 5000 && done_iv < 0 && err_iv < 0; n++) begin
      @(negedge clk);
      cfg_start = (n == st_at);
    end
    cfg_start = 1'b0;
    repeat (expect_to ? 100 : 20) @(negedge clk);
    chk({nm, "_nwrites"}, rise_q.size(), exp_rise.size());
    for (int k = 0; k < exp_rise.size() && k < rise_q.size(); k++) begin
      chk($sformatf("%s_rise%0d", nm, k), rise_q[k] - base, exp_rise[k]);
      chk($sformatf("%s_entry%0d", nm, k), wv_q[k], exp_wv[k]);
    end
    if (expect_to) begin
      chk({nm, "_err_at"}, err_iv - base, exp_end);
      chk({nm, "_fall_at"}, (fall_q.size() > 0) ? fall_q[0] - base : -1, exp_end);
      chk({nm, "_done"}, cfg_done, 0);
    end else begin
      chk({nm, "_done_at"}, done_iv - base, exp_end);
      chk({nm, "_index"}, cfg_index, REG_NUM - 1);
      chk({nm, "_err"}, cfg_err, 0);
    end
    chk({nm, "_busy"}, cfg_busy, 0);
    chk({nm, "_write"}, write, 0);
  endtask

  task automatic load_t1();
    rom[0] = {16'h3008, 8'h82};
    rom[1] = {16'h3103, 8'h03};
    rom[2] = {16'h3017, 8'hFF};
    rom[3] = {16'h3035, 8'h11};
  endtask

  initial begin : main
    for (int i = 0; i < 8; i++) rom[i] = 24'd0;

    // Basic table, fixed entries.
    load_t1();
    lat_base = 40;
    do_reset(1'b1);
    run_check("t1", 1'b0);

    // Delay marker of 5 ms on entry 1.
    load_t1();
    rom[1] = {16'hFFFF, 8'h05};
    lat_base = $urandom_range(0, 40);
    do_reset(1'b0);
    run_check("t2", 1'b0);

    // Randomized tables with random markers.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < REG_NUM; i++) begin
        if ($urandom_range(0, 3) == 0)
          rom[i] = {16'hFFFF, 8'($urandom_range(0, 3))};
        else
          rom[i] = {16'($urandom_range(0, 16'hFFFE)), 8'($urandom_range(0, 255))};
      end
      lat_base = $urandom_range(0, 40);
      do_reset(1'b0);
      run_check($sformatf("rnd%0d", r), 1'b0);
    end

    // No wr_done: timeout into ERROR, then restart with cfg_start.
    load_t1();
    master_en = 1'b0;
    do_reset(1'b0);
    run_check("to", 1'b1);
    master_en = 1'b1;
    lat_base = $urandom_range(0, 40);
    @(negedge clk);
    #1;
    clear_log();
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    base = iv;
    chk("restart_err", cfg_err, 0);
    chk("restart_busy", cfg_busy, 1);
    chk("restart_index", cfg_index, 0);
    run_check("restart", 1'b0);

    // Reset while a write is in flight.
    lat_base = 40;
    do_reset(1'b0);
    for (int n = 0; n < 2000 && !write; n++) @(negedge clk);
    chk("midwr_seen", write, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midwr_write", write, 0);
    chk("midwr_index", cfg_index, 0);
    chk("midwr_busy", cfg_busy, 1);
    @(negedge clk);
    #1;
    clear_log();
    @(negedge clk);
    rst_n = 1'b1;
    base = iv;
    run_check("midwr", 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
